synapse_event_arbiter: RTL and testbench
========================================

Name: synapse_event_arbiter

Overview:
Collects one-cycle rising-edge and falling-edge pulses from NUM_CH edge-detector channels and buffers them as per-channel pending events. Rising edges are excitatory events and falling edges are inhibitory events. A round-robin arbiter serializes the pending events onto a single valid/ready event port that feeds the neuron membrane accumulator. This block is the scheduler that shares one accumulator among all LFSR-driven synapses.

Parameters:
NUM_CH, 4, number of edge-detector channels (2..16)
IDX_W, $clog2(NUM_CH), width of the channel index
CNT_W, 8, width of the drop counter (used only with the optional feature)

Ports:
clk  input  1  system clock, all logic on posedge
reset_i  input  1  synchronous, active-high reset
enable_i  input  1  1 = grants allowed; 0 = hold, no new grants
rising_i  input  NUM_CH  per-channel one-cycle rising-edge pulse (excitatory)
falling_i  input  NUM_CH  per-channel one-cycle falling-edge pulse (inhibitory)
event_valid_o  output  1  an event is presented
event_ready_i  input  1  consumer accepts the event this cycle
event_idx_o  output  IDX_W  channel index of the presented event
event_exc_o  output  1  1 = excitatory (rising), 0 = inhibitory (falling)
overflow_o  output  1  sticky flag: at least one pulse was dropped
pending_o  output  NUM_CH  per-channel OR of both pending bits (debug/status)

Behaviour:
- Reset (reset_i=1 at posedge):
  - All pending bits = 0.
  - event_valid_o = 0, event_idx_o = 0, event_exc_o = 0, overflow_o = 0.
  - RR pointer = 0 (channel 0 has highest priority first).
  - Reset mid-transfer discards the presented event and all pending events.
- Capture:
  - Each channel has two pending bits: pend_exc and pend_inh.
  - rising_i[c] sets pend_exc[c]; falling_i[c] sets pend_inh[c].
- Drop rule:
  - A pulse is dropped if its pending bit is already 1 and is not being granted in the same cycle.
  - A drop sets overflow_o = 1; it stays 1 until reset.
  - A pulse arriving in the same cycle its bit is granted re-sets the bit. This is not a drop.
- State machine, two states:
  - EMPTY: event_valid_o=0.
  - FULL: event_valid_o=1; idx and exc are held stable until the handshake.
- Load condition: (EMPTY or (FULL and event_ready_i)) and enable_i and at least one pending bit set.
  - On load, the arbiter picks the first channel with any pending bit, searching upward from the RR pointer with wrap-around NUM_CH-1 -> 0.
  - Within the chosen channel, excitatory wins when both bits are set.
  - The chosen bit is cleared and the output register is loaded; the state is FULL.
  - The RR pointer moves to chosen+1 mod NUM_CH.
  - A channel with both bits pending therefore has its inhibitory event served on that channel's next turn.
- FULL and event_ready_i with no load: go to EMPTY.
- FULL and not event_ready_i: hold. Output is unchanged, regardless of enable_i.
- enable_i=0: no loads. Capture, drops and a handshake of an already-presented event proceed normally.
- Latency and throughput:
  - A pulse sampled at edge k sets its pending bit at k.
  - It is presented after edge k+1 at the earliest, i.e. 2-cycle latency.
  - Sustained throughput is 1 event/cycle while event_ready_i=1.
- Pending bits are cleared only by a grant or by reset.

Optional Feature:
Macro SYN_ARB_DROP_CNT_EN.
- Defined: adds output port drop_count_o [CNT_W-1:0].
  - Reset to 0.
  - Each cycle it adds the number of pulses dropped that cycle (0..2*NUM_CH).
  - Saturates at 2^CNT_W-1; no wrap.
  - overflow_o behaves identically to the undefined case.
- Undefined: port absent; only the sticky overflow_o reports drops.

Decomposition:
- Shared package/include snn_event_pkg:
  - EVT_EXC=1'b1, EVT_INH=1'b0.
  - Default NUM_CH.
  - Event record layout {exc, idx}, also used by the accumulator.
- One natural sub-module: rr_arbiter.
  - Combinational-plus-pointer.
  - Inputs: req[NUM_CH], advance.
  - Outputs: grant index, grant valid.
  - Owns the RR pointer register.

Test Plan:
- Reset: assert reset_i with pending events and valid=1 -> next cycle valid=0, overflow=0, pending_o=0, drop_count=0.
- Single pulse, NUM_CH=4, ready=1: rising_i=4'b0100 at edge 5 -> valid=1, idx=2, exc=1 after edge 6, for exactly one cycle.
- Round-robin fairness: rising_i=4'b1111 in one cycle, ready=1 -> idx sequence 0,1,2,3 on consecutive cycles. A further 4'b1111 burst is then served 0,1,2,3 again, since the pointer wrapped to 0.
- Backpressure: present idx=1, hold ready=0 for 5 cycles while rising_i[3] pulses -> idx/exc stable; after ready=1, next event idx=3.
- Overflow: with ready=0, pulse falling_i[0] twice -> overflow_o=1 after the second pulse, drop_count=1 (macro on), only one inhibitory event for ch0 delivered.
- Same-channel both polarities plus enable: rising_i[1] and falling_i[1] in the same cycle with enable_i=0 for 3 cycles -> no valid. After enable_i=1: idx=1 exc=1 first, then (ch1 turn again, no others pending) idx=1 exc=0.

Source files
------------

// File: rtl/snn_event_pkg.sv
// -----------------------------------------------------------------------------
// snn_event_pkg
// Shared definitions for the spiking-synapse event path: event polarity
// encodings, the default channel count, the {exc, idx} event record used by
// both the event arbiter and the membrane accumulator, the arbiter FSM state
// type and a population-count helper.
// No ports (package).
// -----------------------------------------------------------------------------
package snn_event_pkg;

  // Event polarity: rising edge = excitatory, falling edge = inhibitory.
  localparam logic EVT_EXC = 1'b1;
  localparam logic EVT_INH = 1'b0;

  // Default number of edge-detector channels feeding one accumulator.
  localparam int NUM_CH_DEFAULT = 4;

  // Widest channel index supported (NUM_CH up to 16).
  localparam int EVT_IDX_W = 4;

  // Event record shared with the accumulator: {exc, idx}.
  typedef struct packed {
    logic                 exc;
    logic [EVT_IDX_W-1:0] idx;
  } snn_event_t;

  // Output-stage state of the event arbiter.
  typedef enum logic [0:0] {
    ARB_EMPTY = 1'b0,
    ARB_FULL  = 1'b1
  } arb_state_e;

  // Number of set bits in a 32-bit vector (0..32).
  function automatic logic [5:0] popcount32(input logic [31:0] vec);
    logic [5:0] cnt;
    cnt = 6'd0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + {5'd0, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin selector over NUM_CH request lines. The search is purely
// combinational and starts at the pointer, wrapping NUM_CH-1 -> 0. The pointer
// register moves to (grant+1) mod NUM_CH whenever the caller takes the grant.
// Ports:
//   clk          system clock
//   reset_i      synchronous active-high reset (pointer -> 0)
//   req          per-channel request vector
//   advance      1 = the current grant is taken this cycle
//   grant_idx    index of the selected channel (valid when grant_valid=1)
//   grant_valid  at least one request is set
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_valid
);

  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] cand_s;
  int               sum_s;

  // Search upward from the pointer for the first requesting channel.
  always_comb begin
    grant_idx   = {IDX_W{1'b0}};
    grant_valid = 1'b0;
    sum_s       = 0;
    cand_s      = {IDX_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      sum_s = int'(ptr_r) + i;
      if (sum_s >= NUM_CH) begin
        sum_s = sum_s - NUM_CH;
      end else begin
        sum_s = sum_s;
      end
      cand_s = IDX_W'(sum_s);
      if (!grant_valid && req[cand_s]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_s;
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

  // Pointer register: the channel after the one just served gets top priority.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      ptr_r <= {IDX_W{1'b0}};
    end else if (advance) begin
      if (grant_idx == IDX_W'(NUM_CH - 1)) begin
        ptr_r <= {IDX_W{1'b0}};
      end else begin
        ptr_r <= grant_idx + IDX_W'(1);
      end
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/synapse_event_arbiter.sv
// -----------------------------------------------------------------------------
// synapse_event_arbiter
// Buffers one-cycle rising/falling edge pulses from NUM_CH edge detectors as
// per-channel pending bits (excitatory / inhibitory) and serializes them,
// round-robin, onto one valid/ready event port feeding the membrane
// accumulator. A pulse hitting an already-pending bit that is not granted in
// the same cycle is dropped and raises the sticky overflow flag.
//
// Optional feature: define SYN_ARB_DROP_CNT_EN to add drop_count_o, a
// saturating CNT_W-bit count of dropped pulses.
//
// Ports:
//   clk            system clock
//   reset_i        synchronous active-high reset
//   enable_i       1 = new grants allowed
//   rising_i       per-channel rising-edge pulse (excitatory)
//   falling_i      per-channel falling-edge pulse (inhibitory)
//   event_valid_o  an event is presented
//   event_ready_i  consumer accepts the presented event
//   event_idx_o    channel index of the presented event
//   event_exc_o    1 = excitatory, 0 = inhibitory
//   overflow_o     sticky: a pulse was dropped since reset
//   drop_count_o   saturating dropped-pulse count (SYN_ARB_DROP_CNT_EN only)
//   pending_o      per-channel OR of both pending bits
// -----------------------------------------------------------------------------
module synapse_event_arbiter
  import snn_event_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEFAULT,
  parameter int IDX_W  = $clog2(NUM_CH)
`ifdef SYN_ARB_DROP_CNT_EN
  ,
  parameter int CNT_W  = 8
`endif
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic [NUM_CH-1:0] rising_i,
  input  logic [NUM_CH-1:0] falling_i,
  output logic              event_valid_o,
  input  logic              event_ready_i,
  output logic [IDX_W-1:0]  event_idx_o,
  output logic              event_exc_o,
  output logic              overflow_o,
`ifdef SYN_ARB_DROP_CNT_EN
  output logic [CNT_W-1:0]  drop_count_o,
`endif
  output logic [NUM_CH-1:0] pending_o
);

  arb_state_e        state_r;
  arb_state_e        state_nxt_s;
  logic [NUM_CH-1:0] pend_exc_r;
  logic [NUM_CH-1:0] pend_inh_r;
  logic [NUM_CH-1:0] pend_exc_nxt_s;
  logic [NUM_CH-1:0] pend_inh_nxt_s;
  logic [NUM_CH-1:0] clr_exc_s;
  logic [NUM_CH-1:0] clr_inh_s;
  logic [NUM_CH-1:0] drop_exc_s;
  logic [NUM_CH-1:0] drop_inh_s;
  logic [NUM_CH-1:0] req_s;
  logic [NUM_CH-1:0] pending_r;
  logic [IDX_W-1:0]  grant_idx_s;
  logic              grant_valid_s;
  logic              grant_exc_s;
  logic              load_s;
  logic              valid_r;
  logic [IDX_W-1:0]  idx_r;
  logic [IDX_W-1:0]  idx_nxt_s;
  logic              exc_r;
  logic              exc_nxt_s;
  logic              ovf_r;

  assign req_s       = pend_exc_r | pend_inh_r;
  // Excitatory wins inside the chosen channel when both bits are pending.
  assign grant_exc_s = pend_exc_r[grant_idx_s];

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_rr_arbiter (
    .clk         (clk),
    .reset_i     (reset_i),
    .req         (req_s),
    .advance     (load_s),
    .grant_idx   (grant_idx_s),
    .grant_valid (grant_valid_s)
  );

  // Load a new event when the output stage is free or being emptied this cycle.
  always_comb begin
    load_s = 1'b0;
    if (enable_i && grant_valid_s &&
        ((state_r == ARB_EMPTY) || event_ready_i)) begin
      load_s = 1'b1;
    end else begin
      load_s = 1'b0;
    end
  end

  // One-hot clear of the granted pending bit.
  always_comb begin
    clr_exc_s = {NUM_CH{1'b0}};
    clr_inh_s = {NUM_CH{1'b0}};
    if (load_s) begin
      if (grant_exc_s) begin
        clr_exc_s[grant_idx_s] = 1'b1;
      end else begin
        clr_inh_s[grant_idx_s] = 1'b1;
      end
    end else begin
      clr_exc_s = {NUM_CH{1'b0}};
      clr_inh_s = {NUM_CH{1'b0}};
    end
  end

  // A pulse arriving while its bit is being granted re-sets it and is not a drop.
  assign drop_exc_s     = rising_i  & pend_exc_r & ~clr_exc_s;
  assign drop_inh_s     = falling_i & pend_inh_r & ~clr_inh_s;
  assign pend_exc_nxt_s = (pend_exc_r & ~clr_exc_s) | rising_i;
  assign pend_inh_nxt_s = (pend_inh_r & ~clr_inh_s) | falling_i;

  // Output-stage next state; a stalled event holds regardless of enable_i.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    exc_nxt_s   = exc_r;
    if (load_s) begin
      state_nxt_s = ARB_FULL;
      idx_nxt_s   = grant_idx_s;
      exc_nxt_s   = grant_exc_s ? EVT_EXC : EVT_INH;
    end else begin
      case (state_r)
        ARB_FULL: begin
          if (event_ready_i) begin
            state_nxt_s = ARB_EMPTY;
          end else begin
            state_nxt_s = ARB_FULL;
          end
        end
        ARB_EMPTY: state_nxt_s = ARB_EMPTY;
        default:   state_nxt_s = ARB_EMPTY;
      endcase
    end
  end

  // State, output registers, pending bits and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_r    <= ARB_EMPTY;
      valid_r    <= 1'b0;
      idx_r      <= {IDX_W{1'b0}};
      exc_r      <= 1'b0;
      pend_exc_r <= {NUM_CH{1'b0}};
      pend_inh_r <= {NUM_CH{1'b0}};
      pending_r  <= {NUM_CH{1'b0}};
      ovf_r      <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      valid_r    <= (state_nxt_s == ARB_FULL);
      idx_r      <= idx_nxt_s;
      exc_r      <= exc_nxt_s;
      pend_exc_r <= pend_exc_nxt_s;
      pend_inh_r <= pend_inh_nxt_s;
      pending_r  <= pend_exc_nxt_s | pend_inh_nxt_s;
      ovf_r      <= ovf_r | (|drop_exc_s) | (|drop_inh_s);
    end
  end

  assign event_valid_o = valid_r;
  assign event_idx_o   = idx_r;
  assign event_exc_o   = exc_r;
  assign overflow_o    = ovf_r;
  assign pending_o     = pending_r;

`ifdef SYN_ARB_DROP_CNT_EN
  // Extra headroom so one cycle's worth of drops cannot wrap the sum.
  localparam int SUM_W = CNT_W + 6;

  logic [CNT_W-1:0] drop_cnt_r;
  logic [5:0]       drop_num_s;
  logic [SUM_W-1:0] drop_sum_s;

  assign drop_num_s = popcount32(32'({drop_inh_s, drop_exc_s}));
  assign drop_sum_s = SUM_W'(drop_cnt_r) + SUM_W'(drop_num_s);

  // Saturating accumulation of dropped pulses.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      drop_cnt_r <= {CNT_W{1'b0}};
    end else if (drop_sum_s > SUM_W'({CNT_W{1'b1}})) begin
      drop_cnt_r <= {CNT_W{1'b1}};
    end else begin
      drop_cnt_r <= drop_sum_s[CNT_W-1:0];
    end
  end

  assign drop_count_o = drop_cnt_r;
`endif

endmodule

// File: tb/tb_synapse_event_arbiter.sv
module tb_synapse_event_arbiter;

  localparam int NUM_CH = 4;
  localparam int IDX_W  = 2;

  logic              clk;
  logic              reset_i;
  logic              enable_i;
  logic [NUM_CH-1:0] rising_i;
  logic [NUM_CH-1:0] falling_i;
  logic              event_valid_o;
  logic              event_ready_i;
  logic [IDX_W-1:0]  event_idx_o;
  logic              event_exc_o;
  logic              overflow_o;
  logic [NUM_CH-1:0] pending_o;
`ifdef SYN_ARB_DROP_CNT_EN
  logic [7:0]        drop_count_o;
`endif

  synapse_event_arbiter dut (
    .clk           (clk),
    .reset_i       (reset_i),
    .enable_i      (enable_i),
    .rising_i      (rising_i),
    .falling_i     (falling_i),
    .event_valid_o (event_valid_o),
    .event_ready_i (event_ready_i),
    .event_idx_o   (event_idx_o),
    .event_exc_o   (event_exc_o),
    .overflow_o    (overflow_o),
`ifdef SYN_ARB_DROP_CNT_EN
    .drop_count_o  (drop_count_o),
`endif
    .pending_o     (pending_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rise;
    logic [3:0] fall;
    logic       en;
    logic       rdy;
    logic       v;
    logic [1:0] idx;
    logic       exc;
    logic       ovf;
    logic [3:0] pend;
    logic [7:0] drop;
  } vec_t;

  typedef struct {
    logic [1:0] idx;
    logic       exc;
  } exp_evt_t;

  vec_t     vecs[$];
  exp_evt_t sb_q[$];
  int       n_checks = 0;
  int       n_errors = 0;
  logic     sb_on    = 1'b0;

  task automatic add(input logic [3:0] rise, input logic [3:0] fall,
                     input logic en, input logic rdy, input logic v,
                     input logic [1:0] idx, input logic exc, input logic ovf,
                     input logic [3:0] pend, input logic [7:0] drop);
    vec_t r;
    r.rise = rise; r.fall = fall; r.en = en; r.rdy = rdy; r.v = v;
    r.idx = idx; r.exc = exc; r.ovf = ovf; r.pend = pend; r.drop = drop;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] idx, input logic exc);
    exp_evt_t e;
    e.idx = idx; e.exc = exc;
    sb_q.push_back(e);
  endtask

  // One clock: score any handshake completing at this edge, then sample #1 after.
  task automatic cycle();
    exp_evt_t e;
    if (sb_on && event_valid_o && event_ready_i) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_extra: unexpected event idx=%0d exc=%0d", event_idx_o, event_exc_o);
      end else begin
        e = sb_q.pop_front();
        chk("sb_idx", 32'(event_idx_o), 32'(e.idx));
        chk("sb_exc", 32'(event_exc_o), 32'(e.exc));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] rise, input logic [3:0] fall,
                       input logic en, input logic rdy);
    rising_i = rise; falling_i = fall; enable_i = en; event_ready_i = rdy;
  endtask

  task automatic do_reset();
    drive(4'b0000, 4'b0000, 1'b1, 1'b1);
    reset_i = 1'b1;
    cycle();
    reset_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1;
    drive(4'b0000, 4'b0000, 1'b1, 1'b1);
    cycle();
    cycle();
    chk("rst_valid", 32'(event_valid_o), 32'd0);
    chk("rst_idx", 32'(event_idx_o), 32'd0);
    chk("rst_exc", 32'(event_exc_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    chk("rst_pend", 32'(pending_o), 32'd0);
`ifdef SYN_ARB_DROP_CNT_EN
    chk("rst_drop", 32'(drop_count_o), 32'd0);
`endif
    reset_i = 1'b0;

    //   rise     fall     en    rdy   v     idx   exc   ovf   pend     drop
    // Round-robin fairness, two bursts
    add(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 8'd0);
    add(4'b1111, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b1111, 8'd0);
    add(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 4'b1110, 8'd0);
    add(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 4'b1100, 8'd0);
    add(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 4'b1000, 8'd0);
    add(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 4'b0000, 8'd0);
    add(4'b1111, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b1111, 8'd0);
    add(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 4'b1110, 8'd0);
    add(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 4'b1100, 8'd0);
    add(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 4'b1000, 8'd0);
    add(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 4'b0000, 8'd0);
    add(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 8'd0);
    // Single pulse: 2-cycle latency, presented for exactly one cycle
    add(4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0100, 8'd0);
    add(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0000, 8'd0);
    add(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 8'd0);
    // Backpressure: idx 1 held through 5 stalled cycles (one with enable low)
    add(4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0010, 8'd0);
    add(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 4'b0000, 8'd0);
    add(4'b1000, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 4'b1000, 8'd0);
    add(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 4'b1000, 8'd0);
    add(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 4'b1000, 8'd0);
    add(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 4'b1000, 8'd0);
    add(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 4'b0000, 8'd0);
    add(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 8'd0);
    // Overflow: second falling_i[0] while pending is dropped
    add(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0100, 8'd0);
    add(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0000, 8'd0);
    add(4'b0000, 4'b0001, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0001, 8'd0);
    add(4'b0000, 4'b0001, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 4'b0001, 8'd1);
    add(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 4'b0000, 8'd1);
    add(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0000, 8'd1);
    add(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0000, 8'd1);
    // Pulse in the cycle its bit is granted re-sets it (no drop)
    add(4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0010, 8'd1);
    add(4'b0010, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 4'b0010, 8'd1);
    add(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 4'b0000, 8'd1);
    add(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0000, 8'd1);
    // Both polarities on ch1 while disabled, then exc first, inh next turn
    add(4'b0010, 4'b0010, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0010, 8'd1);
    add(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0010, 8'd1);
    add(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0010, 8'd1);
    add(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 4'b0010, 8'd1);
    add(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 4'b0000, 8'd1);
    add(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0000, 8'd1);
    // Handshake completes with enable low, but no new load
    add(4'b0001, 4'b0100, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0101, 8'd1);
    add(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 4'b0001, 8'd1);
    add(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0001, 8'd1);
    add(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 4'b0000, 8'd1);
    add(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 4'b0000, 8'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rise, vecs[i].fall, vecs[i].en, vecs[i].rdy);
      cycle();
      chk($sformatf("vec%0d_valid", i), 32'(event_valid_o), 32'(vecs[i].v));
      if (vecs[i].v) begin
        chk($sformatf("vec%0d_idx", i), 32'(event_idx_o), 32'(vecs[i].idx));
        chk($sformatf("vec%0d_exc", i), 32'(event_exc_o), 32'(vecs[i].exc));
      end
      chk($sformatf("vec%0d_ovf", i), 32'(overflow_o), 32'(vecs[i].ovf));
      chk($sformatf("vec%0d_pend", i), 32'(pending_o), 32'(vecs[i].pend));
`ifdef SYN_ARB_DROP_CNT_EN
      chk($sformatf("vec%0d_drop", i), 32'(drop_count_o), 32'(vecs[i].drop));
`endif
    end

    // Reset mid-transfer: pointer sits at 1 here, so a kept pointer would pick ch3.
    drive(4'b1111, 4'b0000, 1'b1, 1'b0);
    cycle();
    drive(4'b0000, 4'b0000, 1'b1, 1'b0);
    cycle();
    chk("pre_rst_valid", 32'(event_valid_o), 32'd1);
    reset_i = 1'b1;
    cycle();
    reset_i = 1'b0;
    chk("mid_rst_valid", 32'(event_valid_o), 32'd0);
    chk("mid_rst_ovf", 32'(overflow_o), 32'd0);
    chk("mid_rst_pend", 32'(pending_o), 32'd0);
`ifdef SYN_ARB_DROP_CNT_EN
    chk("mid_rst_drop", 32'(drop_count_o), 32'd0);
`endif
    drive(4'b0000, 4'b0000, 1'b1, 1'b1);
    cycle();
    chk("post_rst_valid", 32'(event_valid_o), 32'd0);
    drive(4'b1001, 4'b0000, 1'b1, 1'b1);
    cycle();
    drive(4'b0000, 4'b0000, 1'b1, 1'b1);
    cycle();
    chk("post_rst_ptr_valid", 32'(event_valid_o), 32'd1);
    chk("post_rst_ptr_idx", 32'(event_idx_o), 32'd0);

    // Scoreboard stream: all 8 events at once under random backpressure.
    do_reset();
    sb_on = 1'b1;
    for (int c = 0; c < NUM_CH; c++) push_exp(2'(c), 1'b1);
    for (int c = 0; c < NUM_CH; c++) push_exp(2'(c), 1'b0);
    drive(4'b1111, 4'b1111, 1'b1, 1'($urandom_range(0, 1)));
    cycle();
    for (int c = 0; c < 200 && sb_q.size() > 0; c++) begin
      drive(4'b0000, 4'b0000, 1'b1, 1'($urandom_range(0, 1)));
      cycle();
    end
    sb_on = 1'b0;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chk("sb_end_valid", 32'(event_valid_o), 32'd0);
    chk("sb_end_pend", 32'(pending_o), 32'd0);
    chk("sb_end_ovf", 32'(overflow_o), 32'd0);

`ifdef SYN_ARB_DROP_CNT_EN
    // Saturation: 8 drops per cycle on top of a stalled event.
    do_reset();
    drive(4'b0001, 4'b0000, 1'b1, 1'b0);
    cycle();
    drive(4'b1111, 4'b1111, 1'b1, 1'b0);
    cycle();
    chk("sat_first_fill", 32'(drop_count_o), 32'd0);
    for (int c = 0; c < 31; c++) cycle();
    chk("sat_248", 32'(drop_count_o), 32'd248);
    cycle();
    chk("sat_255", 32'(drop_count_o), 32'd255);
    cycle();
    chk("sat_hold", 32'(drop_count_o), 32'd255);
    chk("sat_ovf", 32'(overflow_o), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
